// File: rtl/ext_pkg.sv
// ext_pkg: shared types and constants for the ext_pipe extension unit.
package ext_pkg;

  // Width of the extension-mode field.
  localparam int EXT_MODE_W = 2;

  // Extension modes.
  typedef enum logic [EXT_MODE_W-1:0] {
    EXT_SEXT = 2'd0,
    EXT_ZEXT = 2'd1,
    EXT_HIGH = 2'd2,
    EXT_ONES = 2'd3
  } ext_mode_e;

endpackage

// File: rtl/ext_core.sv
// ext_core: purely combinational field extension.
// Takes the low in_len bits of in_data and widens them to OUTWIDTH bits
// according to in_mode. Illegal lengths give err=1 and data=0.
module ext_core
  import ext_pkg::*;
#(
  parameter int INWIDTH  = 15,
  parameter int OUTWIDTH = 32,
  parameter int LENW     = $clog2(INWIDTH + 1)
) (
  input  logic [INWIDTH-1:0]    in_data,
  input  logic [LENW-1:0]       in_len,
  input  logic [EXT_MODE_W-1:0] in_mode,
  output logic [OUTWIDTH-1:0]   data,
  output logic                  err
);

  logic [OUTWIDTH-1:0] src;
  logic                msb;
  logic                fill;
  int                  len;
  ext_mode_e           mode;

  assign src  = OUTWIDTH'(in_data);
  assign len  = int'(in_len);
  assign mode = ext_mode_e'(in_mode);

  // Extract the field top bit and build the extended result.
  always_comb begin
    err  = (len == 0) || (len > INWIDTH);
    msb  = 1'b0;
    fill = 1'b0;
    data = '0;

    for (int i = 0; i < INWIDTH; i++) begin
      if (i == len - 1) msb = in_data[i];
    end

    case (mode)
      EXT_SEXT: fill = msb;
      EXT_ONES: fill = 1'b1;
      default:  fill = 1'b0;
    endcase

    if (!err) begin
      if (mode == EXT_HIGH) begin
        // Field is left-justified; bits below it stay zero.
        for (int j = 0; j < INWIDTH; j++) begin
          if (j < len) data[OUTWIDTH - len + j] = src[j];
        end
      end else begin
        for (int i = 0; i < OUTWIDTH; i++) begin
          data[i] = (i < len) ? src[i] : fill;
        end
      end
    end
  end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: registered valid/ready wrapper around ext_core.
// Default build keeps a single output register; in_ready is combinational
// in out_ready. Defining EXT_SKID_EN adds a 2-entry skid buffer so in_ready
// becomes a registered signal independent of out_ready.
// Data registers are not reset; out_data/out_err are forced to 0 whenever
// out_valid is low, so reset only needs to clear the control state.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int INWIDTH  = 15,
  parameter int OUTWIDTH = 32,
  localparam int LENW    = $clog2(INWIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INWIDTH-1:0]    in_data,
  input  logic [LENW-1:0]       in_len,
  input  logic [EXT_MODE_W-1:0] in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUTWIDTH-1:0]   out_data,
  output logic                  out_err
);

  logic [OUTWIDTH-1:0] core_data;
  logic                core_err;
  logic                acc;

  ext_core #(
    .INWIDTH (INWIDTH),
    .OUTWIDTH(OUTWIDTH),
    .LENW    (LENW)
  ) u_core (
    .in_data(in_data),
    .in_len (in_len),
    .in_mode(in_mode),
    .data   (core_data),
    .err    (core_err)
  );

  assign acc = in_valid && in_ready;

`ifdef EXT_SKID_EN

  logic [1:0]          cnt_q, cnt_d;
  logic                rdy_q, rdy_d;
  logic [OUTWIDTH-1:0] head_data_q, spare_data_q;
  logic                head_err_q, spare_err_q;
  logic                drn;
  logic                ld_head_new, ld_head_spare, ld_spare;

  assign drn       = (cnt_q != 2'd0) && out_ready;
  assign in_ready  = rdy_q && !rst;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = out_valid ? head_data_q : '0;
  assign out_err   = out_valid && head_err_q;

  // Occupancy update and routing of new/spare entries into the head slot.
  always_comb begin
    cnt_d         = cnt_q;
    ld_head_new   = 1'b0;
    ld_head_spare = 1'b0;
    ld_spare      = 1'b0;
    case (cnt_q)
      2'd0: begin
        if (acc) begin
          ld_head_new = 1'b1;
          cnt_d       = 2'd1;
        end
      end
      2'd1: begin
        if (acc && drn) begin
          ld_head_new = 1'b1;
        end else if (acc) begin
          ld_spare = 1'b1;
          cnt_d    = 2'd2;
        end else if (drn) begin
          cnt_d = 2'd0;
        end
      end
      2'd2: begin
        // in_ready is low when full, so only a drain can happen here.
        if (drn) begin
          ld_head_spare = 1'b1;
          cnt_d         = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase
    rdy_d = (cnt_d != 2'd2);
  end

  // Control state: occupancy and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      rdy_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
    end
  end

  // Data storage for the head and spare entries.
  always_ff @(posedge clk) begin
    if (ld_head_new) begin
      head_data_q <= core_data;
      head_err_q  <= core_err;
    end else if (ld_head_spare) begin
      head_data_q <= spare_data_q;
      head_err_q  <= spare_err_q;
    end
    if (ld_spare) begin
      spare_data_q <= core_data;
      spare_err_q  <= core_err;
    end
  end

`else

  logic                vld_q, vld_d;
  logic [OUTWIDTH-1:0] data_q;
  logic                err_q;

  assign in_ready  = !rst && (!vld_q || out_ready);
  assign vld_d     = acc || (vld_q && !out_ready);
  assign out_valid = vld_q;
  assign out_data  = vld_q ? data_q : '0;
  assign out_err   = vld_q && err_q;

  // Output-valid control.
  always_ff @(posedge clk) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= vld_d;
  end

  // Capture the extended result on acceptance.
  always_ff @(posedge clk) begin
    if (acc) begin
      data_q <= core_data;
      err_q  <= core_err;
    end
  end

`endif

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: scoreboard bench for ext_pipe (INWIDTH=15, OUTWIDTH=32).
module tb_ext_pipe;

`ifdef EXT_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] in_data = '0;
  logic [3:0]  in_len = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_err;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  ext_pipe #(.INWIDTH(15), .OUTWIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_len   (in_len),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  // Reference model, written with wide shifts rather than bit loops.
  function automatic exp_t model(input logic [14:0] d, input int len, input int mode);
    logic [63:0] ones, f, r;
    logic        msb;
    exp_t        x;
    ones = ~64'd0;
    if (len == 0 || len > 15) begin
      x.d = '0;
      x.e = 1'b1;
      return x;
    end
    f   = {49'd0, d} & ~(ones << len);
    msb = d[len-1];
    case (mode)
      0:       r = msb ? (f | (ones << len)) : f;
      1:       r = f;
      2:       r = f << (32 - len);
      default: r = f | (ones << len);
    endcase
    x.d = r[31:0];
    x.e = 1'b0;
    return x;
  endfunction

  // Monitor: samples mid-cycle, pops on handshake, checks ready/stability/idle zeros.
  logic        prev_stall = 1'b0;
  logic        prev_rst   = 1'b0;
  logic [31:0] prev_data  = '0;
  logic        prev_err   = 1'b0;
  always begin
    logic exp_rdy;
    exp_t x;
    @(negedge clk);
    #2;
    exp_rdy = rst ? 1'b0 : (SKID ? (sb.size() < 2) : (!out_valid || out_ready));
    n_checks++;
    if (in_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_rdy);
    end
    if (prev_rst && !rst) begin
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_valid t=%0t got=%b exp=0", $time, out_valid);
      end
    end
    if (prev_stall && !prev_rst) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== prev_data || out_err !== prev_err) begin
        n_fail++;
        $display("FAIL stall_hold t=%0t got=%b/%h/%b exp=1/%h/%b", $time,
                 out_valid, out_data, out_err, prev_data, prev_err);
      end
    end
    if (out_valid !== 1'b1) begin
      n_checks++;
      if (out_data !== 32'd0 || out_err !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_zero t=%0t got=%h/%b exp=0/0", $time, out_data, out_err);
      end
    end
    if (rst) begin
      sb.delete();
    end else if (out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out t=%0t got=%h/%b exp=none", $time, out_data, out_err);
      end else begin
        x = sb.pop_front();
        if (out_data !== x.d || out_err !== x.e) begin
          n_fail++;
          $display("FAIL result t=%0t got=%h/%b exp=%h/%b", $time, out_data, out_err, x.d, x.e);
        end
      end
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_rst   = rst;
    prev_data  = out_data;
    prev_err   = out_err;
  end

  // Present one request and wait (bounded) for acceptance; push expectation on accept.
  task automatic send(input logic [14:0] d, input int len, input int mode);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_len   = 4'(len);
    in_mode  = 2'(mode);
    #1;
    while (!in_ready && waited < 60) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout t=%0t got=in_ready=0 exp=1", $time);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    sb.push_back(model(d, len, mode));
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain;
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    #3;
    n_checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain t=%0t got=pending%0d/valid%b exp=0/0", $time, sb.size(), out_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    #2;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'd0 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got=%b/%b/%h/%b exp=0/0/0/0", in_ready, out_valid, out_data, out_err);
    end
    @(negedge clk);
    rst = 1'b0;
    #2;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset got=%b exp=1", in_ready);
    end
  endtask

  // Directed vectors, each checked for one-cycle latency as well.
  task automatic test_basic;
    logic [14:0] vd[8] = '{15'h4000, 15'h7F80, 15'h7F80, 15'h0003, 15'h7FFF, 15'h1234, 15'h7FFF, 15'h0001};
    int          vl[8] = '{15, 8, 8, 4, 15, 0, 1, 15};
    int          vm[8] = '{0, 0, 1, 3, 2, 1, 0, 2};
    logic [31:0] ed[8] = '{32'hFFFF_C000, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FFF3,
                           32'hFFFE_0000, 32'h0, 32'hFFFF_FFFF, 32'h0002_0000};
    logic        ee[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(vd[i], vl[i], vm[i]);
      @(negedge clk);
      #3;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== ed[i] || out_err !== ee[i]) begin
        n_fail++;
        $display("FAIL directed%0d got=%b/%h/%b exp=1/%h/%b", i, out_valid, out_data, out_err, ed[i], ee[i]);
      end
    end
    drain();
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send(15'(16'h1111 * (i + 1)), 3 + i, i % 4);
      end
      begin
        idle(3);
        out_ready = 1'b0;
        idle(5);
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_random;
    fork
      begin
        for (int i = 0; i < 40; i++) send(15'($urandom), $urandom_range(0, 15), $urandom_range(0, 3));
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_reset_stalled;
    out_ready = 1'b0;
    send(15'h0ABC, 12, 0);
    if (SKID) send(15'h0123, 9, 1);
    idle(1);
    rst = 1'b1;
    #2;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stalled_pre got=%b/%b exp=0/1", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stalled_out got=%b/%h/%b exp=0/0/0", out_valid, out_data, out_err);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #2;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stalled_post got=%b/%b exp=1/0", in_ready, out_valid);
    end
    send(15'h0005, 3, 0);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_random();
    test_reset_stalled();
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 SHALL have parameter INWIDTH, default 15: maximum source field width, 1..OUTWIDTH-1.
REQ-002 SHALL have parameter OUTWIDTH, default 32: result width.
REQ-003 SHALL have derived localparam LENW = $clog2(INWIDTH+1): width of in_len.
REQ-004 clk  input  1  sole clock, rising edge; one clock, reset synchronous and active-high.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  request accepted when in_valid && in_ready at clk edge.
REQ-008 in_data  input  INWIDTH  source field; bits at or above in_len ignored.
REQ-009 in_len  input  LENW  number of meaningful low bits of in_data.
REQ-010 in_mode  input  2  extension mode: 0 SEXT, 1 ZEXT, 2 HIGH, 3 ONES.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-013 out_data  output  OUTWIDTH  extended result.
REQ-014 out_err  output  1  result flagged illegal; qualified by out_valid.

Function
REQ-015 Field f = in_data masked to low in_len bits; msb = in_data[in_len-1].
REQ-016 SEXT SHALL fill bits [OUTWIDTH-1:in_len] with msb.
REQ-017 ZEXT SHALL fill bits [OUTWIDTH-1:in_len] with 0.
REQ-018 ONES SHALL fill bits [OUTWIDTH-1:in_len] with 1.
REQ-019 HIGH SHALL place f at bits [OUTWIDTH-1:OUTWIDTH-in_len], lower bits 0.
REQ-020 in_len == 0 or in_len > INWIDTH SHALL give out_err=1, out_data=0; otherwise out_err=0.
REQ-021 Result SHALL appear on out_data/out_err with out_valid=1 exactly one cycle after acceptance when output stage empty; no combinational in->out path.
REQ-022 out_data/out_err/out_valid SHALL hold stable while out_valid && !out_ready.
REQ-023 Without EXT_SKID_EN, in_ready SHALL equal !out_valid || out_ready; accept and drain in the same cycle sustain one result per cycle.
REQ-024 No request SHALL be dropped or duplicated; results leave in acceptance order.
REQ-025 When out_valid=0, out_data and out_err SHALL be 0.

Reset
REQ-026 rst SHALL take effect at the clk edge regardless of in_valid/out_ready; any held or buffered result is discarded.
REQ-027 During and after reset: out_valid=0, out_data=0, out_err=0; in_ready=1 from the first cycle after rst deasserts.
REQ-028 in_ready SHALL be 0 while rst=1.

Configuration
REQ-029 Macro EXT_SKID_EN SHALL, when defined, add a 2-entry skid buffer: in_ready is a registered signal (=1 when fewer than 2 entries held) with no combinational dependence on out_ready; latency stays 1 cycle when empty.
REQ-030 With EXT_SKID_EN, a request accepted while out_valid && !out_ready SHALL be stored and presented next after the current result drains; in_ready drops to 0 when both entries are full.
REQ-031 Without EXT_SKID_EN, a single output register and REQ-023 apply.

Structure
REQ-032 Package ext_pkg SHALL hold the ext_mode_e enum (EXT_SEXT=0, EXT_ZEXT=1, EXT_HIGH=2, EXT_ONES=3) and the mode width constant.
REQ-033 Combinational extension SHALL be in sub-module ext_core (in_data, in_len, in_mode -> data, err); ext_pipe holds only handshake and storage.

Verification (INWIDTH=15, OUTWIDTH=32)
REQ-034 in_data=15'h4000, len=15, SEXT -> next cycle out_data=32'hFFFF_C000, out_err=0.
REQ-035 in_data=15'h7F80, len=8, SEXT -> 32'hFFFF_FF80; same with ZEXT -> 32'h0000_0080; ONES, len=4, data=15'h0003 -> 32'hFFFF_FFF3.
REQ-036 HIGH, len=15, data=15'h7FFF -> 32'hFFFE_0000; len=0 or len=16 -> out_err=1, out_data=0.
REQ-037 Back-to-back 8 requests with out_ready held 0 for 5 cycles mid-stream -> outputs in order, none lost, out_data stable while stalled; with EXT_SKID_EN, in_ready falls only after 2 entries held.
REQ-038 rst asserted while out_valid=1 and stalled -> next cycle out_valid=0, out_data=0, in_ready=0 during rst, 1 after.
